// File: rtl/rxaccessp_pkg.sv
// Shared constants and FSM encoding for the receive access-code stage.
package rxaccessp_pkg;

  localparam int SW_LEN  = 64;
  localparam int TRL_LEN = 4;
  localparam int WIN_W   = 12;
  localparam int CNT_W   = $clog2(SW_LEN + 1);
  localparam int TRL_W   = $clog2(TRL_LEN);
  localparam int CLK_W   = 28;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_TRAILER = 2'd2,
    ST_PKT     = 2'd3
  } state_t;

endpackage

// File: rtl/rxaccessp_popcnt64.sv
// Registered population count of the sync-word agreement vector.
// This register is the single pipeline stage between the shift register and the hit decision.
module rxaccessp_popcnt64
  import rxaccessp_pkg::*;
(
  input  logic              clk_6M,
  input  logic              rstz,
  input  logic [SW_LEN-1:0] i_vec,
  output logic [CNT_W-1:0]  o_cnt
);

  logic [CNT_W-1:0] w_sum;

  // Adder chain over all agreement bits.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < SW_LEN; i++) begin
      w_sum = w_sum + CNT_W'(i_vec[i]);
    end
  end

  // Register the count.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) o_cnt <= '0;
    else       o_cnt <= w_sum;
  end

endmodule

// File: rtl/rxaccessp.sv
// Receive access-code stage: sync-word correlation, search window, trailer pacing.
//
//  state   | meaning
//  --------+---------------------------------------------------------
//  IDLE    | correlator closed, shift register frozen
//  SEARCH  | correlating each received bit, window counter running
//  TRAILER | sync hit seen, pacing the trailer bits
//  PKT     | header/payload in progress downstream, wait for rx_end
module rxaccessp
  import rxaccessp_pkg::*;
(
  input  logic              clk_6M,
  input  logic              rstz,
  input  logic              p_1us,
  input  logic              demod_bit,
  input  logic              search_en,
  input  logic              id_only,
  input  logic              rx_end,
  input  logic [SW_LEN-1:0] regi_syncword,
  input  logic [CNT_W-1:0]  regi_corr_thresh,
  input  logic [WIN_W-1:0]  regi_win_us,
  input  logic [CLK_W-1:0]  CLK,
  output logic              sync_hit_p,
  output logic              corr_timeout_p,
  output logic              rx_trailer_st_p,
  output logic              rxbit,
  output logic              rx_active,
  output logic [CLK_W-1:0]  hit_CLK,
  output logic [CNT_W-1:0]  hit_count
);

  state_t            r_state;
  logic [SW_LEN-1:0] r_sr;
  logic [CNT_W-1:0]  r_bits_seen;
  logic [WIN_W-1:0]  r_win_cnt;
  logic [TRL_W-1:0]  r_trl_cnt;
  logic              r_tick_d1;
  logic              r_tick_d2;
  logic [CNT_W-1:0]  w_match_q;
  logic              w_hit;
  logic              w_expire;

  rxaccessp_popcnt64 u_popcnt (
    .clk_6M (clk_6M),
    .rstz   (rstz),
    .i_vec  (~(r_sr ^ regi_syncword)),
    .o_cnt  (w_match_q)
  );

  // r_tick_d2 marks the one cycle in which w_match_q reflects the newest bit.
  // Window expiry is evaluated in that same cycle so a simultaneous hit can win.
  assign w_hit    = r_tick_d2 && (r_state == ST_SEARCH) &&
                    (r_bits_seen == CNT_W'(SW_LEN)) && (w_match_q >= regi_corr_thresh);
  assign w_expire = r_tick_d2 && (r_state == ST_SEARCH) &&
                    (regi_win_us != '0) && (r_win_cnt == regi_win_us);

  assign rx_active = (r_state == ST_TRAILER) || (r_state == ST_PKT);

  // Bit sampling: shift register, output bit, bits-seen counter, evaluation strobe.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      r_sr        <= '0;
      rxbit       <= 1'b0;
      r_bits_seen <= '0;
      r_tick_d1   <= 1'b0;
      r_tick_d2   <= 1'b0;
    end else begin
      r_tick_d1 <= p_1us && (r_state != ST_IDLE);
      r_tick_d2 <= r_tick_d1;
      if (p_1us) rxbit <= demod_bit;
      if (r_state == ST_IDLE) begin
        r_bits_seen <= '0;
      end else if (p_1us) begin
        r_sr <= {demod_bit, r_sr[SW_LEN-1:1]};
        if (r_bits_seen != CNT_W'(SW_LEN)) r_bits_seen <= r_bits_seen + CNT_W'(1);
      end
    end
  end

  // Control FSM with registered pulse outputs and hit capture.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      r_state         <= ST_IDLE;
      r_win_cnt       <= '0;
      r_trl_cnt       <= '0;
      sync_hit_p      <= 1'b0;
      corr_timeout_p  <= 1'b0;
      rx_trailer_st_p <= 1'b0;
      hit_CLK         <= '0;
      hit_count       <= '0;
    end else begin
      sync_hit_p      <= 1'b0;
      corr_timeout_p  <= 1'b0;
      rx_trailer_st_p <= 1'b0;
      if (!search_en) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state   <= ST_SEARCH;
            r_win_cnt <= '0;
          end
          ST_SEARCH: begin
            if (p_1us) r_win_cnt <= r_win_cnt + WIN_W'(1);
            if (w_hit) begin
              sync_hit_p <= 1'b1;
              hit_CLK    <= CLK;
              hit_count  <= w_match_q;
              r_trl_cnt  <= '0;
              r_state    <= id_only ? ST_IDLE : ST_TRAILER;
            end else if (w_expire) begin
              corr_timeout_p <= 1'b1;
              r_state        <= ST_IDLE;
            end
          end
          ST_TRAILER: begin
            if (p_1us) begin
              if (r_trl_cnt == TRL_W'(TRL_LEN - 1)) begin
                rx_trailer_st_p <= 1'b1;
                r_state         <= ST_PKT;
              end else begin
                r_trl_cnt <= r_trl_cnt + TRL_W'(1);
              end
            end
          end
          ST_PKT: begin
            if (rx_end) r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rxaccessp.sv
// Scoreboard bench for rxaccessp: stimulus pushes expected pulses, a monitor pops and compares.
module tb_rxaccessp;
  import rxaccessp_pkg::*;

  localparam logic [63:0] SW = 64'h475C58CC73345E72;
  localparam int K_HIT = 0;
  localparam int K_TMO = 1;
  localparam int K_TRL = 2;

  typedef struct {
    int          kind;
    int          cyc;
    logic [6:0]  cnt;
    logic [27:0] clkv;
    state_t      st;
  } exp_t;

  logic        clk_6M = 1'b0;
  logic        rstz, p_1us, demod_bit, search_en, id_only, rx_end;
  logic [63:0] regi_syncword;
  logic [6:0]  regi_corr_thresh;
  logic [11:0] regi_win_us;
  logic [27:0] CLK;
  logic        sync_hit_p, corr_timeout_p, rx_trailer_st_p, rxbit, rx_active;
  logic [27:0] hit_CLK;
  logic [6:0]  hit_count;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_pulses = 0;

  rxaccessp dut (
    .clk_6M(clk_6M), .rstz(rstz), .p_1us(p_1us), .demod_bit(demod_bit),
    .search_en(search_en), .id_only(id_only), .rx_end(rx_end),
    .regi_syncword(regi_syncword), .regi_corr_thresh(regi_corr_thresh),
    .regi_win_us(regi_win_us), .CLK(CLK),
    .sync_hit_p(sync_hit_p), .corr_timeout_p(corr_timeout_p),
    .rx_trailer_st_p(rx_trailer_st_p), .rxbit(rxbit), .rx_active(rx_active),
    .hit_CLK(hit_CLK), .hit_count(hit_count)
  );

  initial forever #5 clk_6M = ~clk_6M;
  always @(posedge clk_6M) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int c, input logic [6:0] cnt,
                      input logic [27:0] clkv, input state_t st);
    exp_t e;
    e.kind = kind; e.cyc = c; e.cnt = cnt; e.clkv = clkv; e.st = st;
    q.push_back(e);
  endtask

  // Monitor: pop an expectation for every pulse the DUT presents.
  initial forever begin
    int   np;
    int   kind;
    exp_t e;
    @(negedge clk_6M);
    np = int'(sync_hit_p) + int'(corr_timeout_p) + int'(rx_trailer_st_p);
    if (np > 1) chk("one_pulse_per_cycle", 64'(np), 64'd1);
    if (np > 0) begin
      n_pulses++;
      kind = sync_hit_p ? K_HIT : (corr_timeout_p ? K_TMO : K_TRL);
      if (q.size() == 0) begin
        chk("unexpected_pulse_kind", 64'(kind), 64'hFF);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", 64'(kind), 64'(e.kind));
        chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
        chk("state_after_pulse", 64'(dut.r_state), 64'(e.st));
        if (e.kind == K_HIT) begin
          chk("hit_count", 64'(hit_count), 64'(e.cnt));
          chk("hit_CLK", 64'(hit_CLK), 64'(e.clkv));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_6M);
    #1;
  endtask

  // Bit i is presented on tick i; tick k lands on clock edge (entry cycle + 1 + 6k).
  task automatic send(input logic [127:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      p_1us = 1'b1;
      demod_bit = bits[i];
      step();
      p_1us = 1'b0;
      chk("rxbit", 64'(rxbit), 64'(bits[i]));
      repeat (5) step();
    end
  endtask

  task automatic start_search(input logic [6:0] th, input logic [11:0] win,
                              input logic id, input logic [27:0] clkv);
    search_en = 1'b0;
    regi_corr_thresh = th;
    regi_win_us = win;
    id_only = id;
    CLK = clkv;
    step();
    search_en = 1'b1;
    step();
    step();
  endtask

  initial begin
    logic [127:0] v;
    int np0;
    rstz = 1'b0; p_1us = 1'b0; demod_bit = 1'b0; search_en = 1'b0;
    id_only = 1'b0; rx_end = 1'b0; regi_syncword = SW;
    regi_corr_thresh = 7'd64; regi_win_us = '0; CLK = '0;
    repeat (3) step();
    chk("rst_sync_hit_p", 64'(sync_hit_p), 64'd0);
    chk("rst_corr_timeout_p", 64'(corr_timeout_p), 64'd0);
    chk("rst_rx_trailer_st_p", 64'(rx_trailer_st_p), 64'd0);
    chk("rst_rxbit", 64'(rxbit), 64'd0);
    chk("rst_rx_active", 64'(rx_active), 64'd0);
    chk("rst_hit_CLK", 64'(hit_CLK), 64'd0);
    chk("rst_hit_count", 64'(hit_count), 64'd0);
    chk("rst_state", 64'(dut.r_state), 64'(ST_IDLE));
    rstz = 1'b1;
    step();

    // Exact sync word, full threshold, ID packet.
    start_search(7'd64, 12'd0, 1'b1, 28'h1000001);
    push(K_HIT, cyc + 1 + 6*63 + 2, 7'd64, 28'h1000001, ST_IDLE);
    v = '0; v[63:0] = SW;
    send(v, 64);

    // Three bits flipped: threshold 61 hits with 61, threshold 62 does not.
    v = '0; v[63:0] = SW ^ 64'h8000_0000_0010_0001;
    start_search(7'd61, 12'd0, 1'b1, 28'h2000002);
    push(K_HIT, cyc + 1 + 6*63 + 2, 7'd61, 28'h2000002, ST_IDLE);
    send(v, 64);
    start_search(7'd62, 12'd0, 1'b1, 28'h3000003);
    np0 = n_pulses;
    send(v, 64);
    chk("thresh62_no_hit", 64'(n_pulses), 64'(np0));

    // Threshold 0 on all-zero data hits on the first evaluation; count = 64 - popcount(SW) = 32.
    start_search(7'd0, 12'd0, 1'b1, 28'h4000004);
    push(K_HIT, cyc + 1 + 6*63 + 2, 7'd32, 28'h4000004, ST_IDLE);
    v = '0;
    send(v, 64);

    // Threshold above 64 never hits.
    start_search(7'd65, 12'd0, 1'b1, 28'h5000005);
    np0 = n_pulses;
    v = '0; v[63:0] = SW;
    send(v, 64);
    chk("thresh65_no_hit", 64'(n_pulses), 64'(np0));

    // 100 us window with non-matching data: timeout tied to the 100th tick.
    start_search(7'd64, 12'd100, 1'b1, 28'h6000006);
    v = '0;
    for (int i = 0; i < 100; i++) v[i] = (i % 3 == 0);
    push(K_TMO, cyc + 1 + 6*99 + 2, 7'd0, 28'd0, ST_IDLE);
    send(v, 100);

    // Full packet: hit, trailer, PKT, rx_end.
    start_search(7'd64, 12'd0, 1'b0, 28'h7000007);
    push(K_HIT, cyc + 1 + 6*63 + 2, 7'd64, 28'h7000007, ST_TRAILER);
    v = '0; v[63:0] = SW;
    send(v, 64);
    chk("trailer_rx_active", 64'(rx_active), 64'd1);
    rx_end = 1'b1; step(); rx_end = 1'b0;
    chk("rx_end_ignored_in_trailer", 64'(dut.r_state), 64'(ST_TRAILER));
    v = '0; v[7:0] = 8'b0110_1101;
    push(K_TRL, cyc + 1 + 6*3, 7'd0, 28'd0, ST_PKT);
    send(v, 8);
    chk("pkt_rx_active", 64'(rx_active), 64'd1);
    rx_end = 1'b1; step(); rx_end = 1'b0;
    chk("rx_end_rx_active", 64'(rx_active), 64'd0);
    chk("rx_end_state", 64'(dut.r_state), 64'(ST_IDLE));

    // ID packet: hit only, no trailer afterwards.
    start_search(7'd64, 12'd0, 1'b1, 28'h8000008);
    np0 = n_pulses;
    push(K_HIT, cyc + 1 + 6*63 + 2, 7'd64, 28'h8000008, ST_IDLE);
    v = '0; v[63:0] = SW;
    send(v, 64);
    v = '0; v[5:0] = 6'b101101;
    send(v, 6);
    chk("id_only_single_pulse", 64'(n_pulses), 64'(np0 + 1));
    chk("id_only_rx_active", 64'(rx_active), 64'd0);

    // Abort during TRAILER by dropping search_en.
    start_search(7'd64, 12'd0, 1'b0, 28'h9000009);
    push(K_HIT, cyc + 1 + 6*63 + 2, 7'd64, 28'h9000009, ST_TRAILER);
    v = '0; v[63:0] = SW;
    send(v, 64);
    v = '0; v[1:0] = 2'b11;
    send(v, 2);
    search_en = 1'b0;
    step();
    chk("abort_state", 64'(dut.r_state), 64'(ST_IDLE));
    chk("abort_rx_active", 64'(rx_active), 64'd0);
    np0 = n_pulses;
    send(v, 4);
    chk("abort_no_trailer", 64'(n_pulses), 64'(np0));

    // Reset during TRAILER.
    start_search(7'd64, 12'd0, 1'b0, 28'hA00000A);
    push(K_HIT, cyc + 1 + 6*63 + 2, 7'd64, 28'hA00000A, ST_TRAILER);
    v = '0; v[63:0] = SW;
    send(v, 64);
    v = '0; v[1:0] = 2'b01;
    send(v, 2);
    rstz = 1'b0;
    #1;
    chk("midrst_state", 64'(dut.r_state), 64'(ST_IDLE));
    chk("midrst_rx_active", 64'(rx_active), 64'd0);
    chk("midrst_trailer_st", 64'(rx_trailer_st_p), 64'd0);
    chk("midrst_hit_count", 64'(hit_count), 64'd0);
    chk("midrst_hit_CLK", 64'(hit_CLK), 64'd0);
    step();
    rstz = 1'b1;
    np0 = n_pulses;
    v = '0; v[5:0] = 6'b110011;
    send(v, 6);
    chk("midrst_no_pulse", 64'(n_pulses), 64'(np0));

    repeat (10) step();
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("missing_pulse_cycle", 64'hFFFF_FFFF, 64'(e.cyc));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
